// File: rtl/e203_predec_pkg.sv
// Shared definitions for the IFU predecode queue.
//   - RV32 opcode / funct7 constants used by the predecoder
//   - muldiv_op_e : funct3 encoding of M-extension operations
//   - predec_t    : per-instruction decode result stored in each queue entry
// prdt_pc is held at PC_MAX_W bits so one struct type serves every PC_W
// instantiation; users take the low PC_W bits.
package e203_predec_pkg;

  localparam int unsigned PC_MAX_W = 64;

  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } muldiv_op_e;

  typedef struct packed {
    logic                rv32;
    logic                bjp;
    logic                jal;
    logic                jalr;
    logic                bxx;
    logic                muldiv;
    muldiv_op_e          muldiv_op;
    logic                rs1en;
    logic                rs2en;
    logic [4:0]          rs1idx;
    logic [4:0]          rs2idx;
    logic [31:0]         bjp_imm;
    logic                prdt_taken;
    logic [PC_MAX_W-1:0] prdt_pc;
  } predec_t;

endpackage

// File: rtl/e203_ifu_predec_dec.sv
// Combinational instruction predecoder.
//   instr [31:0]   : fetched instruction
//   pc    [PC_W-1:0]: its PC
//   dec   predec_t : branch class, muldiv, source regs, branch immediate,
//                    static prediction (backward-taken) and predicted next PC
// Optional: define E203_PREDEC_RVC_EN to decode RVC control-flow instructions
// (c.j, c.jal, c.jr, c.jalr, c.beqz, c.bnez). Otherwise RVC decodes to zeros.
module e203_ifu_predec_dec
  import e203_predec_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic [31:0]     instr,
  input  logic [PC_W-1:0] pc,
  output predec_t         dec
);

  logic [PC_W-1:0] tgt_pc;
  logic [PC_W-1:0] seq_pc;

  always_comb begin
    dec    = '0;
    tgt_pc = '0;
    seq_pc = '0;

    dec.rv32 = (instr[1:0] == 2'b11);

    if (dec.rv32) begin
      dec.rs1idx = instr[19:15];
      dec.rs2idx = instr[24:20];
      unique case (instr[6:0])
        OPC_JAL: begin
          dec.jal     = 1'b1;
          dec.bjp_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        end
        OPC_JALR: begin
          dec.jalr    = 1'b1;
          dec.rs1en   = 1'b1;
          dec.bjp_imm = {{20{instr[31]}}, instr[31:20]};
        end
        OPC_BRANCH: begin
          dec.bxx     = 1'b1;
          dec.rs1en   = 1'b1;
          dec.rs2en   = 1'b1;
          dec.bjp_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        end
        OPC_OP: begin
          if (instr[31:25] == FUNCT7_MULDIV) begin
            dec.muldiv    = 1'b1;
            dec.muldiv_op = muldiv_op_e'(instr[14:12]);
            dec.rs1en     = 1'b1;
            dec.rs2en     = 1'b1;
          end
        end
        default: ;
      endcase
    end
`ifdef E203_PREDEC_RVC_EN
    else begin
      // c.j / c.jal
      if (instr[1:0] == 2'b01 && (instr[15:13] == 3'b101 || instr[15:13] == 3'b001)) begin
        dec.jal     = 1'b1;
        dec.bjp_imm = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6],
                       instr[7], instr[2], instr[11], instr[5:3], 1'b0};
      end
      // c.jr / c.jalr: bit12 only distinguishes link, both are indirect jumps
      else if (instr[1:0] == 2'b10 && instr[15:13] == 3'b100 &&
               instr[6:2] == 5'd0 && instr[11:7] != 5'd0) begin
        dec.jalr   = 1'b1;
        dec.rs1en  = 1'b1;
        dec.rs1idx = instr[11:7];
      end
      // c.beqz / c.bnez
      else if (instr[1:0] == 2'b01 && instr[15:14] == 2'b11) begin
        dec.bxx     = 1'b1;
        dec.rs1en   = 1'b1;
        dec.rs1idx  = {2'b01, instr[9:7]};
        dec.bjp_imm = {{23{instr[12]}}, instr[12], instr[6:5], instr[2],
                       instr[11:10], instr[4:3], 1'b0};
      end
    end
`endif

    dec.bjp        = dec.jal | dec.jalr | dec.bxx;
    dec.prdt_taken = dec.jal | (dec.bxx & dec.bjp_imm[31]);

    tgt_pc      = pc + PC_W'($signed(dec.bjp_imm));
    seq_pc      = pc + (dec.rv32 ? PC_W'(4) : PC_W'(2));
    dec.prdt_pc = PC_MAX_W'(dec.prdt_taken ? tgt_pc : seq_pc);
  end

endmodule

// File: rtl/e203_ifu_predec_queue.sv
// IFU predecode queue: DEPTH-entry circular buffer between fetch return and
// the IFU pipeline / BPU. Each instruction is predecoded on enqueue and the
// head entry is presented with its decode fields and static prediction.
//   clk, rst (sync, active-high), flush (empties the queue, drops a same-cycle push)
//   i_valid/i_ready/i_instr/i_pc : enqueue side, i_ready = !full
//   o_valid/o_ready/o_*           : head entry, o_valid = !empty, no bypass
//   count                         : occupancy
// DEPTH must be a power of two >= 2; PC_W must not exceed 64.
// Optional: E203_PREDEC_RVC_EN enables RVC control-flow decode in the predecoder.
module e203_ifu_predec_queue
  import e203_predec_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     i_valid,
  output logic                     i_ready,
  input  logic [31:0]              i_instr,
  input  logic [PC_W-1:0]          i_pc,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [31:0]              o_instr,
  output logic [PC_W-1:0]          o_pc,
  output logic                     o_rv32,
  output logic                     o_bjp,
  output logic                     o_jal,
  output logic                     o_jalr,
  output logic                     o_bxx,
  output logic                     o_muldiv,
  output logic [2:0]               o_muldiv_op,
  output logic                     o_rs1en,
  output logic                     o_rs2en,
  output logic [4:0]               o_rs1idx,
  output logic [4:0]               o_rs2idx,
  output logic [31:0]              o_bjp_imm,
  output logic                     o_prdt_taken,
  output logic [PC_W-1:0]          o_prdt_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  predec_t         enq_dec;
  predec_t         head;
  predec_t         dec_mem   [DEPTH];
  logic [31:0]     instr_mem [DEPTH];
  logic [PC_W-1:0] pc_mem    [DEPTH];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          prdt_pc_unused;

  e203_ifu_predec_dec #(
    .PC_W (PC_W)
  ) u_dec (
    .instr (i_instr),
    .pc    (i_pc),
    .dec   (enq_dec)
  );

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign i_ready = ~full;
  assign o_valid = ~empty;
  assign push    = i_valid & i_ready;
  assign pop     = o_valid & o_ready;

  // Control state. Flush wins over push/pop; pointers wrap naturally since
  // DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  // Entry storage is not reset; a write during flush is harmless because the
  // pointers are cleared in the same cycle.
  always_ff @(posedge clk) begin
    if (push) begin
      dec_mem[wptr]   <= enq_dec;
      instr_mem[wptr] <= i_instr;
      pc_mem[wptr]    <= i_pc;
    end
  end

  assign head           = dec_mem[rptr];
  assign o_instr        = instr_mem[rptr];
  assign o_pc           = pc_mem[rptr];
  assign o_rv32         = head.rv32;
  assign o_bjp          = head.bjp;
  assign o_jal          = head.jal;
  assign o_jalr         = head.jalr;
  assign o_bxx          = head.bxx;
  assign o_muldiv       = head.muldiv;
  assign o_muldiv_op    = head.muldiv_op;
  assign o_rs1en        = head.rs1en;
  assign o_rs2en        = head.rs2en;
  assign o_rs1idx       = head.rs1idx;
  assign o_rs2idx       = head.rs2idx;
  assign o_bjp_imm      = head.bjp_imm;
  assign o_prdt_taken   = head.prdt_taken;
  assign o_prdt_pc      = head.prdt_pc[PC_W-1:0];
  // Upper prdt_pc bits beyond PC_W are always zero and intentionally unused.
  assign prdt_pc_unused = ^head.prdt_pc;

endmodule

// File: tb/tb_e203_ifu_predec_queue.sv
module tb_e203_ifu_predec_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready;
  logic [31:0] i_instr = '0;
  logic [31:0] i_pc = '0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_rv32, o_bjp, o_jal, o_jalr, o_bxx, o_muldiv;
  logic [2:0]  o_muldiv_op;
  logic        o_rs1en, o_rs2en;
  logic [4:0]  o_rs1idx, o_rs2idx;
  logic [31:0] o_bjp_imm;
  logic        o_prdt_taken;
  logic [31:0] o_prdt_pc;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_err = 0;

  e203_ifu_predec_queue #(
    .DEPTH (4),
    .PC_W  (32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .i_valid      (i_valid),
    .i_ready      (i_ready),
    .i_instr      (i_instr),
    .i_pc         (i_pc),
    .o_valid      (o_valid),
    .o_ready      (o_ready),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .o_rv32       (o_rv32),
    .o_bjp        (o_bjp),
    .o_jal        (o_jal),
    .o_jalr       (o_jalr),
    .o_bxx        (o_bxx),
    .o_muldiv     (o_muldiv),
    .o_muldiv_op  (o_muldiv_op),
    .o_rs1en      (o_rs1en),
    .o_rs2en      (o_rs2en),
    .o_rs1idx     (o_rs1idx),
    .o_rs2idx     (o_rs2idx),
    .o_bjp_imm    (o_bjp_imm),
    .o_prdt_taken (o_prdt_taken),
    .o_prdt_pc    (o_prdt_pc),
    .count        (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
    i_valid = 1'b1; i_instr = instr; i_pc = pc;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic pop_one();
    o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL reset_o_valid got %b exp 0", o_valid); end
    n_cmp++; if (i_ready !== 1'b1) begin n_err++; $display("FAIL reset_i_ready got %b exp 1", i_ready); end
    n_cmp++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", count); end
    rst = 1'b0;
  endtask

  task automatic test_jal();
    i_valid = 1'b1; i_instr = 32'h008000EF; i_pc = 32'h80000000;
    #1;
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL jal_no_bypass got %b exp 0", o_valid); end
    tick();
    i_valid = 1'b0;
    n_cmp++; if (o_valid !== 1'b1) begin n_err++; $display("FAIL jal_o_valid got %b exp 1", o_valid); end
    n_cmp++; if (count !== 3'd1) begin n_err++; $display("FAIL jal_count got %0d exp 1", count); end
    n_cmp++; if (o_instr !== 32'h008000EF) begin n_err++; $display("FAIL jal_instr got %h exp 008000ef", o_instr); end
    n_cmp++; if (o_pc !== 32'h80000000) begin n_err++; $display("FAIL jal_pc got %h exp 80000000", o_pc); end
    n_cmp++; if ({o_rv32, o_bjp, o_jal, o_jalr, o_bxx, o_muldiv} !== 6'b111000)
      begin n_err++; $display("FAIL jal_flags got %b exp 111000", {o_rv32, o_bjp, o_jal, o_jalr, o_bxx, o_muldiv}); end
    n_cmp++; if (o_bjp_imm !== 32'h00000008) begin n_err++; $display("FAIL jal_imm got %h exp 00000008", o_bjp_imm); end
    n_cmp++; if (o_prdt_taken !== 1'b1) begin n_err++; $display("FAIL jal_taken got %b exp 1", o_prdt_taken); end
    n_cmp++; if (o_prdt_pc !== 32'h80000008) begin n_err++; $display("FAIL jal_prdt_pc got %h exp 80000008", o_prdt_pc); end
    pop_one();
    n_cmp++; if (o_valid !== 1'b0) begin n_err++; $display("FAIL jal_pop_empty got %b exp 0", o_valid); end
  endtask

  task automatic test_branch();
    push_one(32'hFE208EE3, 32'h80000100);
    n_cmp++; if ({o_bjp, o_jal, o_jalr, o_bxx} !== 4'b1001)
      begin n_err++; $display("FAIL beq_flags got %b exp 1001", {o_bjp, o_jal, o_jalr, o_bxx}); end
    n_cmp++; if ({o_rs1en, o_rs2en, o_rs1idx, o_rs2idx} !== {2'b11, 5'd1, 5'd2})
      begin n_err++; $display("FAIL beq_regs got %b exp %b", {o_rs1en, o_rs2en, o_rs1idx, o_rs2idx}, {2'b11, 5'd1, 5'd2}); end
    n_cmp++; if (o_bjp_imm !== 32'hFFFFFFFC) begin n_err++; $display("FAIL beq_imm got %h exp fffffffc", o_bjp_imm); end
    n_cmp++; if (o_prdt_taken !== 1'b1) begin n_err++; $display("FAIL beq_taken got %b exp 1", o_prdt_taken); end
    n_cmp++; if (o_prdt_pc !== 32'h800000FC) begin n_err++; $display("FAIL beq_prdt_pc got %h exp 800000fc", o_prdt_pc); end
    pop_one();
    // forward branch beq x0,x0,+8: not predicted taken
    push_one(32'h00000463, 32'h00000400);
    n_cmp++; if (o_bjp_imm !== 32'h00000008) begin n_err++; $display("FAIL fwd_imm got %h exp 00000008", o_bjp_imm); end
    n_cmp++; if (o_prdt_taken !== 1'b0) begin n_err++; $display("FAIL fwd_taken got %b exp 0", o_prdt_taken); end
    n_cmp++; if (o_prdt_pc !== 32'h00000404) begin n_err++; $display("FAIL fwd_prdt_pc got %h exp 00000404", o_prdt_pc); end
    pop_one();
    // jalr x0,0(x1): never predicted
    push_one(32'h00008067, 32'h00000800);
    n_cmp++; if ({o_bjp, o_jalr, o_rs1en, o_rs1idx} !== {3'b111, 5'd1})
      begin n_err++; $display("FAIL jalr_flags got %b exp %b", {o_bjp, o_jalr, o_rs1en, o_rs1idx}, {3'b111, 5'd1}); end
    n_cmp++; if ({o_prdt_taken, o_prdt_pc} !== {1'b0, 32'h00000804})
      begin n_err++; $display("FAIL jalr_prdt got %b/%h exp 0/00000804", o_prdt_taken, o_prdt_pc); end
    pop_one();
  endtask

  task automatic test_muldiv();
    push_one(32'h025251B3, 32'h00000010);
    n_cmp++; if ({o_muldiv, o_bjp, o_muldiv_op} !== 5'b10101)
      begin n_err++; $display("FAIL divu_flags got %b exp 10101", {o_muldiv, o_bjp, o_muldiv_op}); end
    n_cmp++; if ({o_rs1en, o_rs2en, o_rs1idx, o_rs2idx} !== {2'b11, 5'd4, 5'd5})
      begin n_err++; $display("FAIL divu_regs got %b exp %b", {o_rs1en, o_rs2en, o_rs1idx, o_rs2idx}, {2'b11, 5'd4, 5'd5}); end
    n_cmp++; if (o_bjp_imm !== 32'h0) begin n_err++; $display("FAIL divu_imm got %h exp 0", o_bjp_imm); end
    n_cmp++; if ({o_prdt_taken, o_prdt_pc} !== {1'b0, 32'h00000014})
      begin n_err++; $display("FAIL divu_prdt got %b/%h exp 0/00000014", o_prdt_taken, o_prdt_pc); end
    pop_one();
  endtask

  task automatic test_full();
    o_ready = 1'b0;
    i_instr = 32'h00000013;
    for (int k = 0; k < 6; k++) begin
      i_valid = 1'b1;
      i_pc = 32'h1000 + 32'(4 * k);
      tick();
    end
    n_cmp++; if (count !== 3'd4) begin n_err++; $display("FAIL full_count got %0d exp 4", count); end
    n_cmp++; if (i_ready !== 1'b0) begin n_err++; $display("FAIL full_i_ready got %b exp 0", i_ready); end
    n_cmp++; if (o_pc !== 32'h1000) begin n_err++; $display("FAIL full_head got %h exp 00001000", o_pc); end
    // pop while full with a pushing producer: no push-through
    i_pc = 32'h3000; o_ready = 1'b1;
    tick();
    n_cmp++; if ({count, i_ready} !== {3'd3, 1'b1}) begin n_err++; $display("FAIL full_pop got count %0d rdy %b exp 3/1", count, i_ready); end
    n_cmp++; if (o_pc !== 32'h1004) begin n_err++; $display("FAIL full_pop_head got %h exp 00001004", o_pc); end
    i_valid = 1'b0;
    tick();
    n_cmp++; if ({count, o_pc} !== {3'd2, 32'h1008}) begin n_err++; $display("FAIL pop2 got %0d/%h exp 2/00001008", count, o_pc); end
    i_valid = 1'b1; i_pc = 32'h2000;
    tick();
    i_valid = 1'b0;
    n_cmp++; if ({count, o_pc} !== {3'd2, 32'h100C}) begin n_err++; $display("FAIL pushpop got %0d/%h exp 2/0000100c", count, o_pc); end
    tick();
    n_cmp++; if ({count, o_pc} !== {3'd1, 32'h2000}) begin n_err++; $display("FAIL fifo_last got %0d/%h exp 1/00002000", count, o_pc); end
    tick();
    o_ready = 1'b0;
    n_cmp++; if ({count, o_valid} !== {3'd0, 1'b0}) begin n_err++; $display("FAIL drain got %0d/%b exp 0/0", count, o_valid); end
  endtask

  task automatic test_flush_rst();
    push_one(32'h00000013, 32'h4000);
    push_one(32'h00000013, 32'h4004);
    push_one(32'h00000013, 32'h4008);
    n_cmp++; if (count !== 3'd3) begin n_err++; $display("FAIL pre_flush_count got %0d exp 3", count); end
    flush = 1'b1; i_valid = 1'b1; i_pc = 32'h400C; o_ready = 1'b1;
    tick();
    flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    n_cmp++; if ({count, o_valid, i_ready} !== {3'd0, 1'b0, 1'b1})
      begin n_err++; $display("FAIL flush got %0d/%b/%b exp 0/0/1", count, o_valid, i_ready); end
    push_one(32'h00000013, 32'h5000);
    n_cmp++; if ({count, o_pc} !== {3'd1, 32'h5000}) begin n_err++; $display("FAIL post_flush got %0d/%h exp 1/00005000", count, o_pc); end
    push_one(32'h00000013, 32'h5004);
    push_one(32'h00000013, 32'h5008);
    rst = 1'b1; i_valid = 1'b1; i_pc = 32'h500C; o_ready = 1'b1;
    tick();
    rst = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
    n_cmp++; if ({count, o_valid, i_ready} !== {3'd0, 1'b0, 1'b1})
      begin n_err++; $display("FAIL mid_rst got %0d/%b/%b exp 0/0/1", count, o_valid, i_ready); end
    push_one(32'h00000013, 32'h6000);
    n_cmp++; if ({count, o_pc} !== {3'd1, 32'h6000}) begin n_err++; $display("FAIL post_rst got %0d/%h exp 1/00006000", count, o_pc); end
    pop_one();
  endtask

  task automatic test_rvc();
    push_one(32'h0000BFF5, 32'h00000200);
`ifdef E203_PREDEC_RVC_EN
    n_cmp++; if ({o_rv32, o_jal, o_bjp, o_bjp_imm} !== {3'b011, 32'hFFFFFFFC})
      begin n_err++; $display("FAIL cj_decode got %b/%b/%b/%h exp 0/1/1/fffffffc", o_rv32, o_jal, o_bjp, o_bjp_imm); end
    n_cmp++; if ({o_prdt_taken, o_prdt_pc} !== {1'b1, 32'h000001FC})
      begin n_err++; $display("FAIL cj_prdt got %b/%h exp 1/000001fc", o_prdt_taken, o_prdt_pc); end
`else
    n_cmp++; if ({o_rv32, o_bjp, o_jal, o_jalr, o_bxx, o_muldiv, o_rs1en, o_rs2en} !== 8'b0)
      begin n_err++; $display("FAIL rvc_flags got %b exp 00000000", {o_rv32, o_bjp, o_jal, o_jalr, o_bxx, o_muldiv, o_rs1en, o_rs2en}); end
    n_cmp++; if ({o_rs1idx, o_rs2idx, o_bjp_imm} !== 42'b0)
      begin n_err++; $display("FAIL rvc_fields got %h/%h/%h exp 0/0/0", o_rs1idx, o_rs2idx, o_bjp_imm); end
    n_cmp++; if ({o_prdt_taken, o_prdt_pc} !== {1'b0, 32'h00000202})
      begin n_err++; $display("FAIL rvc_prdt got %b/%h exp 0/00000202", o_prdt_taken, o_prdt_pc); end
`endif
    pop_one();
  endtask

  initial begin
    test_reset();
    test_jal();
    test_branch();
    test_muldiv();
    test_full();
    test_flush_rst();
    test_rvc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
